elevator_trip_sequencer: RTL

Cabin sequencing controller for the elevator. It latches floor requests, picks travel direction with a sweep policy (keep direction while requests remain ahead, else reverse) and times travel and door-open phases. Phases are timed by counting seconds from the 100 MHz→1 Hz timer/divider, which this block drives through its start and restart inputs. It sits between the button/obstruction inputs and the motor/door drivers.

---
 rtl/elevator_trip_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/elevator_trip_sequencer.sv
// elevator_trip_sequencer: cabin controller for a single elevator.
// Latches floor requests, chooses travel direction with a sweep policy
// (keep going while requests remain ahead, otherwise reverse), and times
// floor-to-floor travel and door-open phases by counting 1 Hz edges.
// Optional feature macro: DOOR_REOPEN_EN (door_block restarts the door count).
module elevator_trip_sequencer #(
    parameter int FLOORS      = 4,
    parameter int TRAVEL_SECS = 2,
    parameter int DOOR_SECS   = 10
) (
    input  logic              C_100Mhz,
    input  logic              reset,
    input  logic [FLOORS-1:0] floor_req,
    input  logic              door_block,
    input  logic              c_1hz,
    output logic              timer_start,
    output logic              timer_restart,
    output logic [3:0]        current_floor,
    output logic              moving_up,
    output logic              moving_down,
    output logic              door_open,
    output logic [FLOORS-1:0] pending
);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    state_t            state_q, state_d;
    logic              dir_q, dir_d;          // 1 = up
    logic [3:0]        cur_q, cur_d;
    logic [FLOORS-1:0] pend_q, pend_d;
    logic [3:0]        sec_q, sec_d;
    logic              c1_prev_q, c1_prev_d;
    logic              ign_q, ign_d;          // cycle after a restart pulse
    logic              restart_q, restart_d;
    logic              start_q, start_d;
    logic              up_q, up_d;
    logic              dn_q, dn_d;
    logic              door_q, door_d;

    logic [FLOORS-1:0] cur_hot, above, below, up_hot, dn_hot, nxt_hot, req_all;
    logic              req_here, edge_seen, ahead, behind;
    logic [3:0]        sec_inc;

`ifndef DOOR_REOPEN_EN
    logic unused_door_block;
    assign unused_door_block = door_block;
`endif

    // Floor position masks relative to the cabin: here, above, below, neighbours.
    always_comb begin
        cur_hot = '0;
        above   = '0;
        below   = '0;
        up_hot  = '0;
        dn_hot  = '0;
        for (int i = 0; i < FLOORS; i++) begin
            cur_hot[i] = (cur_q == 4'(i));
            above[i]   = (4'(i) > cur_q);
            below[i]   = (4'(i) < cur_q);
            up_hot[i]  = (4'(i) == cur_q + 4'd1);
            dn_hot[i]  = (4'(i) == cur_q - 4'd1);
        end
    end

    // Next-state, request latching, second counting and registered output decode.
    always_comb begin
        // Rising edges during the restart cycle and the one after it are dropped,
        // which hides the divider toggle caused by the realignment.
        edge_seen = c_1hz & ~c1_prev_q & ~restart_q & ~ign_q;
        sec_inc   = sec_q + 4'd1;
        req_all   = pend_q | floor_req;
        req_here  = |(floor_req & cur_hot);
        ahead     = dir_q ? |(pend_q & above) : |(pend_q & below);
        behind    = dir_q ? |(pend_q & below) : |(pend_q & above);
        nxt_hot   = dir_q ? up_hot : dn_hot;

        state_d   = state_q;
        dir_d     = dir_q;
        cur_d     = cur_q;
        pend_d    = req_all;
        sec_d     = sec_q;
        restart_d = 1'b0;
        ign_d     = restart_q;
        c1_prev_d = c_1hz;

        case (state_q)
            IDLE: begin
                sec_d = 4'd0;
                if (|(pend_q & cur_hot)) begin
                    pend_d    = req_all & ~cur_hot;
                    state_d   = DOOR;
                    restart_d = 1'b1;
                end else if (ahead) begin
                    state_d   = MOVE;
                    restart_d = 1'b1;
                end else if (behind) begin
                    dir_d     = ~dir_q;
                    state_d   = MOVE;
                    restart_d = 1'b1;
                end
            end
            MOVE: begin
                if (edge_seen) begin
                    if (sec_inc == 4'(TRAVEL_SECS)) begin
                        cur_d     = dir_q ? cur_q + 4'd1 : cur_q - 4'd1;
                        sec_d     = 4'd0;
                        restart_d = 1'b1;
                        // A request arriving in this same cycle still stops the cabin.
                        if (|(req_all & nxt_hot)) begin
                            pend_d  = req_all & ~nxt_hot;
                            state_d = DOOR;
                        end
                    end else begin
                        sec_d = sec_inc;
                    end
                end
            end
            DOOR: begin
                // The door is already serving this floor, so its button only
                // extends the open time instead of queueing a new stop.
                pend_d = pend_q | (floor_req & ~cur_hot);
`ifdef DOOR_REOPEN_EN
                if (door_block) begin
                    sec_d     = 4'd0;
                    restart_d = 1'b1;
                end else
`endif
                if (req_here) begin
                    sec_d = 4'd0;
                end else if (edge_seen) begin
                    if (sec_inc == 4'(DOOR_SECS)) begin
                        state_d = IDLE;
                        sec_d   = 4'd0;
                    end else begin
                        sec_d = sec_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sec_d   = 4'd0;
            end
        endcase

        start_d = (state_d != IDLE);
        door_d  = (state_d == DOOR);
        up_d    = (state_d == MOVE) &  dir_d;
        dn_d    = (state_d == MOVE) & ~dir_d;
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge C_100Mhz) begin
        if (reset) begin
            state_q   <= IDLE;
            dir_q     <= 1'b1;
            cur_q     <= 4'd0;
            pend_q    <= '0;
            sec_q     <= 4'd0;
            c1_prev_q <= 1'b0;
            ign_q     <= 1'b0;
            restart_q <= 1'b0;
            start_q   <= 1'b0;
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
            door_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            cur_q     <= cur_d;
            pend_q    <= pend_d;
            sec_q     <= sec_d;
            c1_prev_q <= c1_prev_d;
            ign_q     <= ign_d;
            restart_q <= restart_d;
            start_q   <= start_d;
            up_q      <= up_d;
            dn_q      <= dn_d;
            door_q    <= door_d;
        end
    end

    assign timer_start   = start_q;
    assign timer_restart = restart_q;
    assign current_floor = cur_q;
    assign moving_up     = up_q;
    assign moving_down   = dn_q;
    assign door_open     = door_q;
    assign pending       = pend_q;

endmodule
